// File: rtl/ram_2port_clr.sv
// Simple dual-port RAM with registered read, read-valid flag and a clear sequencer.
// Define RAM2P_BYPASS_EN for write-first same-address read-during-write (default read-first).
module ram_2port_clr #(
   parameter int unsigned          DATA_W    = 4,
   parameter int unsigned          ADDR_W    = 5,
   parameter logic [DATA_W-1:0]    CLR_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr_w,
   input  logic [DATA_W-1:0] data_w,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr_r,
   output logic [DATA_W-1:0] data_r,
   output logic              rd_valid,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   clr_addr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word;

   // Storage is deliberately not reset; the sequencer owns the write port while clearing.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_addr] <= CLR_VALUE;
      end else if (wr_en) begin
         mem[addr_w] <= data_w;
      end
   end

`ifdef RAM2P_BYPASS_EN
   always_comb begin
      rd_word = mem[addr_r];
      if (wr_en && (addr_w == addr_r)) begin
         rd_word = data_w;
      end
   end
`else
   always_comb begin
      rd_word = mem[addr_r];
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
         busy     <= 1'b1;
         data_r   <= '0;
         rd_valid <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               rd_valid <= 1'b0;
               if (clr_addr == '1) begin
                  clr_addr <= '0;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            IDLE: begin
               // A clear request still lets the same-edge read/write complete.
               if (clear) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end
               rd_valid <= rd_en;
               if (rd_en) begin
                  data_r <= rd_word;
               end
            end
            default: begin
               state <= CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_2port_clr.sv
// Scoreboard bench for ram_2port_clr: reads push expected data, a monitor pops on rd_valid.
module tb_ram_2port_clr;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       wr_en;
   logic [4:0] addr_w;
   logic [3:0] data_w;
   logic       rd_en;
   logic [4:0] addr_r;
   logic [3:0] data_r;
   logic       rd_valid;
   logic       busy;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q [$];

   ram_2port_clr #(.DATA_W(4), .ADDR_W(5), .CLR_VALUE(4'h0)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .wr_en(wr_en), .addr_w(addr_w), .data_w(data_w),
      .rd_en(rd_en), .addr_r(addr_r),
      .data_r(data_r), .rd_valid(rd_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every rd_valid cycle must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rd_valid: got data %0h with no read pending", data_r);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (data_r !== e) begin
               errors++;
               $display("FAIL read_data: got %0h expected %0h", data_r, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      clear = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic wait_idle(input int start, input int exp_edges, input string name);
      int n;
      n = start;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, n, exp_edges);
   endtask

   task automatic do_write(input int a, input int d);
      wr_en  = 1'b1;
      addr_w = 5'(a);
      data_w = 4'(d);
      step();
   endtask

   task automatic do_read(input int a, input int e);
      rd_en  = 1'b1;
      addr_r = 5'(a);
      exp_q.push_back(4'(e));
      step();
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      addr_w = '0; data_w = '0; addr_r = '0;
      #2 reset = 1'b1;
      #1;
      check("reset_busy", int'(busy), 1);
      check("reset_data_r", int'(data_r), 0);
      check("reset_rd_valid", int'(rd_valid), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      wait_idle(0, 32, "reset_clear_edges");

      do_read(0, 0);
      do_read(17, 0);
      do_read(31, 0);
      step();

      do_write(1, 4'hA);
      do_read(1, 4'hA);
      check("after_read_valid", int'(rd_valid), 1);
      step();
      check("idle_rd_valid", int'(rd_valid), 0);
      check("idle_data_hold", int'(data_r), 4'hA);

      do_write(3, 4'h5);
      wr_en = 1'b1; addr_w = 5'd3; data_w = 4'hC;
`ifdef RAM2P_BYPASS_EN
      do_read(3, 4'hC);
`else
      do_read(3, 4'h5);
`endif
      do_read(3, 4'hC);
      step();

      for (int i = 0; i < 32; i++) do_write(i, 31 - i);
      do_read(0, 4'hF);
      do_read(20, 4'hB);
      clear = 1'b1;
      step();
      check("clear_busy_rise", int'(busy), 1);
      wr_en = 1'b1; addr_w = 5'd2; data_w = 4'hF;
      rd_en = 1'b1; addr_r = 5'd4;
      clear = 1'b1;
      step();
      wait_idle(1, 32, "clear_edges");
      for (int i = 0; i < 32; i++) do_read(i, 0);
      step();

      do_write(5, 4'h7);
      do_read(5, 4'h7);
      clear = 1'b1;
      step();
      repeat (10) step();
      check("pre_reset_data_r", int'(data_r), 4'h7);
      reset = 1'b1;
      #1;
      check("midclr_reset_busy", int'(busy), 1);
      check("midclr_reset_data_r", int'(data_r), 0);
      check("midclr_reset_rd_valid", int'(rd_valid), 0);
      step();
      reset = 1'b0;
      wait_idle(0, 32, "midclr_restart_edges");

      for (int i = 0; i <= 30; i++) begin
         wr_en  = 1'b1;
         addr_w = 5'(i + 1);
         data_w = 4'((i + 1) * 3 + 1);
         do_read(i, (i == 0) ? 0 : ((i * 3 + 1) & 15));
         check("interleave_rd_valid", int'(rd_valid), 1);
      end
      step();
      step();
      check("pending_reads", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
